gaussian_cdt_sampler: RTL and testbench

- Consumer end of the uniform-RNG interface. Requests 64-bit uniform words from the Tausworthe generator through its ce/valid_out/data_out handshake.
- Converts each word into a signed discrete-Gaussian sample by a constant-time cumulative-distribution-table (CDT) scan.
- Presents samples on a valid/ready stream to the downstream polynomial/noise logic.
- The CDT is a writable register file, loaded by software while the block is idle.

---
 rtl/gaussian_cdt_sampler.sv | 153 +++++++++++++++
 tb/tb_gaussian_cdt_sampler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/gaussian_cdt_sampler.sv
// Purpose : discrete-Gaussian sampler; pulls 64-bit uniform words from the RNG and
//           maps each to a signed sample with a constant-time CDT scan.
// Latency : REQ->sample_valid = N_ENTRIES+3 cycles with a 1-cycle RNG; a rejected
//           word costs one extra full round.
// Backpr. : sample held in OUT until sample_ready; no new RNG request meanwhile.
//
// Ports:
//   clk, rstn                  clock, async active-low reset
//   en                         run enable (current sample always completes)
//   tab_we/tab_addr/tab_wdata  CDT threshold write port, honoured only in IDLE
//   rng_ce                     one-cycle request pulse to the RNG
//   rng_valid/rng_data         RNG answer; bit 63 = sign, bits 62:0 = magnitude draw
//   sample_valid/sample_ready  output stream handshake
//   sample_out                 signed sample, two's complement
//   busy                       high outside IDLE
//   rej_cnt                    saturating count of rejected words
module gaussian_cdt_sampler #(
  parameter int N_ENTRIES = 16,
  parameter int ADDR_W    = 4,
  parameter int OUT_W     = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              tab_we,
  input  logic [ADDR_W-1:0] tab_addr,
  input  logic [62:0]       tab_wdata,
  output logic              rng_ce,
  input  logic              rng_valid,
  input  logic [63:0]       rng_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [OUT_W-1:0]  sample_out,
  output logic              busy,
  output logic [15:0]       rej_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_SCAN, S_RESOLVE, S_OUT
  } state_t;

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(N_ENTRIES - 1);
  localparam logic [ADDR_W:0]   LP_N    = (ADDR_W + 1)'(N_ENTRIES);

  state_t             r_state;
  state_t             w_next;
  logic [62:0]        r_tab [N_ENTRIES];
  logic [62:0]        r_r;
  logic               r_sgn;
  logic [ADDR_W-1:0]  r_idx;
  logic [ADDR_W:0]    r_acc;
  logic [OUT_W-1:0]   r_sample;
  logic               r_valid;
  logic [15:0]        r_rej;

  logic               w_hit;
  logic               w_last;
  logic               w_reject;
  logic               w_tab_wr;
  logic [OUT_W-1:0]   w_mag;
  logic [OUT_W-1:0]   w_signed;

  // One threshold compared per cycle; every entry is visited regardless of the
  // outcome so timing never depends on the drawn value.
  assign w_hit    = (r_r >= r_tab[r_idx]);
  assign w_last   = (r_idx == LP_LAST);
  // r=0 with negative sign would duplicate the zero sample; dropping it keeps
  // the distribution symmetric.
  assign w_reject = (r_acc == '0) && r_sgn;
  assign w_tab_wr = (r_state == S_IDLE) && tab_we && ({1'b0, tab_addr} < LP_N);
  assign w_mag    = OUT_W'(r_acc);
  assign w_signed = r_sgn ? (-w_mag) : w_mag;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (en) w_next = S_REQ;
      S_REQ:     w_next = S_WAIT;
      S_WAIT:    if (rng_valid) w_next = S_SCAN;
      S_SCAN:    if (w_last) w_next = S_RESOLVE;
      S_RESOLVE: w_next = w_reject ? S_REQ : S_OUT;
      S_OUT:     if (sample_ready) w_next = en ? S_REQ : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    rng_ce = (r_state == S_REQ);
    busy   = (r_state != S_IDLE);
  end

  // CDT register file
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_ENTRIES; i++) r_tab[i] <= '0;
    end else if (w_tab_wr) begin
      r_tab[tab_addr] <= tab_wdata;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_r      <= '0;
      r_sgn    <= 1'b0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_rej    <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (rng_valid) begin
            r_r   <= rng_data[62:0];
            r_sgn <= rng_data[63];
            r_idx <= '0;
            r_acc <= '0;
          end
        end
        S_SCAN: begin
          r_acc <= r_acc + {{ADDR_W{1'b0}}, w_hit};
          r_idx <= r_idx + 1'b1;
        end
        S_RESOLVE: begin
          if (w_reject) begin
            if (r_rej != 16'hFFFF) r_rej <= r_rej + 16'd1;
          end else begin
            r_sample <= w_signed;
            r_valid  <= 1'b1;
          end
        end
        S_OUT: begin
          if (sample_ready) r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sample_valid = r_valid;
  assign sample_out   = r_sample;
  assign rej_cnt      = r_rej;

endmodule

// File: tb/tb_gaussian_cdt_sampler.sv
// Bench for gaussian_cdt_sampler: directed words with hand-computed samples,
// a one-cycle-latency RNG model, latency/backpressure/reset/en-drop checks.
module tb_gaussian_cdt_sampler;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        tab_we;
  logic [3:0]  tab_addr;
  logic [62:0] tab_wdata;
  logic        rng_ce;
  logic        rng_valid;
  logic [63:0] rng_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  sample_out;
  logic        busy;
  logic [15:0] rej_cnt;

  int n_chk = 0;
  int n_err = 0;
  int ce_count = 0;
  logic ce_at_edge = 1'b0;
  logic [63:0] word_q[$];

  always #5 clk = ~clk;

  gaussian_cdt_sampler #(.N_ENTRIES(16), .ADDR_W(4), .OUT_W(8)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .tab_we(tab_we), .tab_addr(tab_addr), .tab_wdata(tab_wdata),
    .rng_ce(rng_ce), .rng_valid(rng_valid), .rng_data(rng_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_out(sample_out), .busy(busy), .rej_cnt(rej_cnt)
  );

  // RNG model: a request seen in one cycle is answered with valid in the next.
  always @(negedge clk) ce_at_edge = rng_ce;
  always @(posedge clk) begin
    #1;
    if (ce_at_edge) ce_count++;
    if (ce_at_edge && word_q.size() > 0) begin
      rng_valid = 1'b1;
      rng_data  = word_q.pop_front();
    end else begin
      rng_valid = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic write_tab(input int a, input logic [62:0] d);
    @(negedge clk);
    tab_we = 1'b1; tab_addr = 4'(a); tab_wdata = d;
    @(negedge clk);
    tab_we = 1'b0;
  endtask

  // Raise en until the request is seen, wait en_hold more cycles, drop en,
  // then wait for the sample. Returns cycles from the REQ cycle to sample_valid.
  task automatic start_and_wait(input int en_hold, output int lat);
    int k;
    en = 1'b1;
    k = 0;
    while (!rng_ce && k < 50) begin @(negedge clk); k++; end
    chk("req_seen", {63'd0, rng_ce}, 64'd1);
    lat = 0;
    for (int j = 0; j < en_hold; j++) begin @(negedge clk); lat++; end
    en = 1'b0;
    while (!sample_valid && lat < 200) begin @(negedge clk); lat++; end
  endtask

  task automatic run_sample(input string tag, input logic [63:0] w, input logic [7:0] exp,
                            input int exp_lat);
    int lat;
    int c0;
    c0 = ce_count;
    word_q.push_back(w);
    sample_ready = 1'b1;
    start_and_wait(0, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_out"}, {56'd0, sample_out}, {56'd0, exp});
    @(negedge clk);
    chk({tag, "_vld_clr"}, {63'd0, sample_valid}, 64'd0);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    chk({tag, "_ce_pulses"}, 64'(ce_count - c0), 64'(exp_lat > 19 ? 2 : 1));
  endtask

  initial begin
    int lat;
    int c0;
    rstn = 1'b0; en = 1'b0; tab_we = 1'b0; tab_addr = '0; tab_wdata = '0;
    sample_ready = 1'b0; rng_valid = 1'b0; rng_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_vld", {63'd0, sample_valid}, 64'd0);
    chk("rst_ce", {63'd0, rng_ce}, 64'd0);
    chk("rst_rej", {48'd0, rej_cnt}, 64'd0);
    chk("rst_out", {56'd0, sample_out}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) write_tab(i, 63'(i + 1) << 58);

    // r = 3<<58 meets T[0..2] -> +3 / -3
    run_sample("pos3", 64'h0C00_0000_0000_0000, 8'h03, 19);
    run_sample("neg3", 64'h8C00_0000_0000_0000, 8'hFD, 19);

    // r=0, sgn=1 is rejected; the next word (0) yields 0 one round later
    word_q.push_back(64'h8000_0000_0000_0000);
    run_sample("rej", 64'h0000_0000_0000_0000, 8'h00, 38);
    chk("rej_cnt", {48'd0, rej_cnt}, 64'd1);

    // Backpressure: sample held, no requests, table write ignored
    c0 = ce_count;
    word_q.push_back(64'h0C00_0000_0000_0000);
    sample_ready = 1'b0;
    start_and_wait(0, lat);
    chk("hold_lat", 64'(lat), 64'd19);
    write_tab(5, 63'd0);
    for (int j = 0; j < 8; j++) @(negedge clk);
    chk("hold_vld", {63'd0, sample_valid}, 64'd1);
    chk("hold_out", {56'd0, sample_out}, 64'h03);
    chk("hold_no_ce", 64'(ce_count - c0), 64'd1);
    sample_ready = 1'b1;
    @(negedge clk);
    chk("hold_hs", {63'd0, sample_valid}, 64'd0);
    run_sample("tab_kept", 64'h0C00_0000_0000_0000, 8'h03, 19);

    // Reset in the middle of a scan
    word_q.push_back(64'h0C00_0000_0000_0000);
    en = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    rstn = 1'b0;
    en = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_vld", {63'd0, sample_valid}, 64'd0);
    chk("arst_rej", {48'd0, rej_cnt}, 64'd0);
    word_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Table cleared: every threshold is 0, so any draw counts 16
    run_sample("zero_tab", 64'h8000_0000_0000_0005, 8'hF0, 19);

    // en dropped during the scan: sample still delivered, then IDLE
    c0 = ce_count;
    word_q.push_back(64'h0C00_0000_0000_0000);
    sample_ready = 1'b1;
    start_and_wait(5, lat);
    chk("endrop_lat", 64'(lat), 64'd19);
    chk("endrop_out", {56'd0, sample_out}, 64'h10);
    repeat (5) @(negedge clk);
    chk("endrop_idle", {63'd0, busy}, 64'd0);
    chk("endrop_ce", 64'(ce_count - c0), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
